// File: rtl/qq_cmd_frontend_if.sv
// rtl/qq_cmd_frontend_if.sv - signal bundle between qq_cmd_frontend, its command source, the queue core and the response sink
//
// Purpose: groups the command handshake, the core strobe/status signals and the response pulse.
// Modports:
//   slave  - the frontend: receives commands and core status, drives ready, strobes, response and occupancy
//   master - the surrounding environment: drives commands and core status, observes the rest
// Signals:
//   in_valid/in_ready/in_op/in_key   command handshake (op 0 = enqueue, 1 = dequeue)
//   core_enq/core_deq/core_key       one-cycle strobes and key toward the queue core
//   core_idle/head_key               core status and current minimum key
//   rsp_valid/rsp_err/rsp_key        command completion pulse
//   occupancy                        keys currently held by the core
interface qq_cmd_frontend_if #(
  parameter int KW       = 32,
  parameter int CAPACITY = 64
);
  localparam int OW = $clog2(CAPACITY + 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [KW-1:0] in_key;
  logic          core_enq;
  logic          core_deq;
  logic [KW-1:0] core_key;
  logic          core_idle;
  logic [KW-1:0] head_key;
  logic          rsp_valid;
  logic          rsp_err;
  logic [KW-1:0] rsp_key;
  logic [OW-1:0] occupancy;

  modport slave (
    input  in_valid, in_op, in_key, core_idle, head_key,
    output in_ready, core_enq, core_deq, core_key, rsp_valid, rsp_err, rsp_key, occupancy
  );

  modport master (
    output in_valid, in_op, in_key, core_idle, head_key,
    input  in_ready, core_enq, core_deq, core_key, rsp_valid, rsp_err, rsp_key, occupancy
  );
endinterface

// File: rtl/qq_cmd_frontend.sv
// rtl/qq_cmd_frontend.sv - command FIFO and issue FSM in front of the priority queue core
//
// Purpose: buffers enqueue/dequeue commands, rejects commands that would overflow or
// underflow the core, issues the rest one at a time and reports completion.
// Ports:
//   clk  clock, posedge
//   rst  synchronous active-high reset
//   bus  qq_cmd_frontend_if.slave (command in, core strobes/status, response, occupancy)
module qq_cmd_frontend #(
  parameter int CMD_DEPTH = 4,
  parameter int CAPACITY  = 64,
  parameter int KW        = 32
) (
  input  logic               clk,
  input  logic               rst,
  qq_cmd_frontend_if.slave   bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int OW = $clog2(CAPACITY + 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(CMD_DEPTH);
  localparam logic [OW-1:0] CAP_L   = OW'(CAPACITY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t state, state_next;

  logic [KW:0]   fifo_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic          fifo_empty;
  logic          head_op;
  logic [KW-1:0] head_cmd_key;
  logic          reject;
  logic          issue, err_rsp, ok_rsp;

  logic          core_enq_r, core_deq_r, rsp_valid_r, rsp_err_r;
  logic [KW-1:0] core_key_r, rsp_key_r;
  logic [OW-1:0] occ;

  // ---------------- command FIFO ----------------
  assign bus.in_ready = (count != DEPTH_L);
  assign push         = bus.in_valid && bus.in_ready;
  assign fifo_empty   = (count == '0);
  assign {head_op, head_cmd_key} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.in_op, bus.in_key};
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- issue FSM ----------------
  // A command the core cannot honour is answered locally without touching the core.
  assign reject = head_op ? (occ == '0) : (occ == CAP_L);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    issue      = 1'b0;
    err_rsp    = 1'b0;
    ok_rsp     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (reject) begin
            pop     = 1'b1;
            err_rsp = 1'b1;
          end else if (bus.core_idle) begin
            issue      = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE:      state_next = WAIT_START;
      // The core may still report idle right after the strobe; wait until it is seen busy.
      WAIT_START: if (!bus.core_idle) state_next = WAIT_DONE;
      // The entry stays at the FIFO head until completion so ISSUE can still read its op.
      WAIT_DONE: begin
        if (bus.core_idle) begin
          pop        = 1'b1;
          ok_rsp     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      core_enq_r  <= 1'b0;
      core_deq_r  <= 1'b0;
      core_key_r  <= '0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_key_r   <= '0;
      occ         <= '0;
    end else begin
      // Strobes are launched on the IDLE->ISSUE edge so they are high during ISSUE.
      core_enq_r  <= issue && !head_op;
      core_deq_r  <= issue && head_op;
      if (issue) core_key_r <= head_cmd_key;
      rsp_valid_r <= err_rsp || ok_rsp;
      rsp_err_r   <= err_rsp;
      if (err_rsp)
        rsp_key_r <= '0;
      else if (state == ISSUE)
        rsp_key_r <= head_op ? bus.head_key : '0;
      if (ok_rsp) begin
        if (head_op) occ <= (occ != '0)   ? occ - 1'b1 : occ;
        else         occ <= (occ != CAP_L) ? occ + 1'b1 : occ;
      end
    end
  end

  assign bus.core_enq  = core_enq_r;
  assign bus.core_deq  = core_deq_r;
  assign bus.core_key  = core_key_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_key   = rsp_key_r;
  assign bus.occupancy = occ;
endmodule
